// File: rtl/dual_issue_regfile.sv
// Purpose : 32x32 register file, two writeback slots, four decode read ports, write-first bypass.
// Latency : reads 0 cycles (combinational); writes, wawCollision and writeCount update on the rising edge.
// Backpressure: none; every port is accepted every cycle.
//
// Ports:
//   clk, rst                        - clock, asynchronous active-low reset
//   regWriteW1/2, writeRegisterW1/2 - writeback enables and destination indices (slot 2 is younger)
//   writeDataW1/2                   - writeback data
//   rsD1, rtD1, rsD2, rtD2          - decode source indices for issue slots 1 and 2
//   readDataA1/B1/A2/B2             - source operands for rsD1/rtD1/rsD2/rtD2
//   wawCollision                    - previous cycle had both slots writing the same nonzero register
//   writeCount                      - wrapping count of committed register writes
module dual_issue_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        regWriteW1,
  input  logic        regWriteW2,
  input  logic [4:0]  writeRegisterW1,
  input  logic [4:0]  writeRegisterW2,
  input  logic [31:0] writeDataW1,
  input  logic [31:0] writeDataW2,
  input  logic [4:0]  rsD1,
  input  logic [4:0]  rtD1,
  input  logic [4:0]  rsD2,
  input  logic [4:0]  rtD2,
  output logic [31:0] readDataA1,
  output logic [31:0] readDataB1,
  output logic [31:0] readDataA2,
  output logic [31:0] readDataB2,
  output logic        wawCollision,
  output logic [15:0] writeCount
);

  // Entry 0 is cleared by reset and never written, so it always holds 0.
  logic [31:0] regs [0:31];

  logic       activeW1;
  logic       activeW2;
  logic       sameDest;
  logic       wrEn1;
  logic       wrEn2;
  logic [1:0] numWrites;

  // A slot is "active" when it writes a nonzero register; this also drives the bypass.
  assign activeW1  = regWriteW1 && (writeRegisterW1 != 5'd0);
  assign activeW2  = regWriteW2 && (writeRegisterW2 != 5'd0);
  assign sameDest  = activeW1 && activeW2 && (writeRegisterW1 == writeRegisterW2);

  // On a same-register pair the older slot-1 write is dropped, so the pair counts once.
  assign wrEn1     = activeW1 && !sameDest;
  assign wrEn2     = activeW2;
  assign numWrites = {1'b0, wrEn1} + {1'b0, wrEn2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      wawCollision <= 1'b0;
      writeCount   <= '0;
    end else begin
      if (wrEn1) begin
        regs[writeRegisterW1] <= writeDataW1;
      end
      if (wrEn2) begin
        regs[writeRegisterW2] <= writeDataW2;
      end
      wawCollision <= sameDest;
      writeCount   <= writeCount + 16'(numWrites);
    end
  end

  // Write-first read: younger slot 2 wins over slot 1, which wins over the stored value.
  // Stored values are already 0 during reset, so only bypassed data can appear then.
  function automatic logic [31:0] readPort(input logic [4:0] idx);
    logic [31:0] val;
    val = regs[idx];
    if (idx == 5'd0) begin
      val = '0;
    end else if (activeW2 && (writeRegisterW2 == idx)) begin
      val = writeDataW2;
    end else if (activeW1 && (writeRegisterW1 == idx)) begin
      val = writeDataW1;
    end
    return val;
  endfunction

  always_comb begin
    readDataA1 = readPort(rsD1);
    readDataB1 = readPort(rtD1);
    readDataA2 = readPort(rsD2);
    readDataB2 = readPort(rtD2);
  end

endmodule

// File: tb/tb_dual_issue_regfile.sv
module tb_dual_issue_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        regWriteW1 = 1'b0;
  logic        regWriteW2 = 1'b0;
  logic [4:0]  writeRegisterW1 = '0;
  logic [4:0]  writeRegisterW2 = '0;
  logic [31:0] writeDataW1 = '0;
  logic [31:0] writeDataW2 = '0;
  logic [4:0]  rsD1 = '0;
  logic [4:0]  rtD1 = '0;
  logic [4:0]  rsD2 = '0;
  logic [4:0]  rtD2 = '0;
  logic [31:0] readDataA1;
  logic [31:0] readDataB1;
  logic [31:0] readDataA2;
  logic [31:0] readDataB2;
  logic        wawCollision;
  logic [15:0] writeCount;

  int nCompared   = 0;
  int nMismatched = 0;

  dual_issue_regfile dut (
    .clk             (clk),
    .rst             (rst),
    .regWriteW1      (regWriteW1),
    .regWriteW2      (regWriteW2),
    .writeRegisterW1 (writeRegisterW1),
    .writeRegisterW2 (writeRegisterW2),
    .writeDataW1     (writeDataW1),
    .writeDataW2     (writeDataW2),
    .rsD1            (rsD1),
    .rtD1            (rtD1),
    .rsD2            (rsD2),
    .rtD2            (rtD2),
    .readDataA1      (readDataA1),
    .readDataB1      (readDataB1),
    .readDataA2      (readDataA2),
    .readDataB2      (readDataB2),
    .wawCollision    (wawCollision),
    .writeCount      (writeCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleWrites();
    regWriteW1 = 1'b0;
    regWriteW2 = 1'b0;
    writeRegisterW1 = '0;
    writeRegisterW2 = '0;
    writeDataW1 = '0;
    writeDataW2 = '0;
  endtask

  initial begin
    // ---- reset: async assertion, outputs cleared, bypass still visible, write suppressed
    #1 rst = 1'b0;
    #1;
    check("rst_writeCount", 32'(writeCount), 32'd0);
    check("rst_waw", 32'(wawCollision), 32'd0);
    rsD1 = 5'd4;
    #1;
    check("rst_read_r4", readDataA1, 32'd0);
    regWriteW1 = 1'b1; writeRegisterW1 = 5'd3; writeDataW1 = 32'h3333_3333;
    rsD1 = 5'd3;
    #1;
    check("rst_bypass_r3", readDataA1, 32'h3333_3333);
    tick();
    idleWrites();
    rst = 1'b1;
    #1;
    for (int i = 1; i < 32; i++) begin
      rsD1 = 5'(i); rtD1 = 5'(i); rsD2 = 5'(i); rtD2 = 5'(i);
      #1;
      check($sformatf("reset_A1_r%0d", i), readDataA1, 32'd0);
      check($sformatf("reset_B1_r%0d", i), readDataB1, 32'd0);
      check($sformatf("reset_A2_r%0d", i), readDataA2, 32'd0);
      check($sformatf("reset_B2_r%0d", i), readDataB2, 32'd0);
    end
    check("reset_waw", 32'(wawCollision), 32'd0);
    check("reset_writeCount", 32'(writeCount), 32'd0);

    // ---- first edge after reset with enables low: nothing written or counted
    tick();
    check("idle_writeCount", 32'(writeCount), 32'd0);

    // ---- dual write to r5 and r6
    regWriteW1 = 1'b1; writeRegisterW1 = 5'd5; writeDataW1 = 32'h1111_1111;
    regWriteW2 = 1'b1; writeRegisterW2 = 5'd6; writeDataW2 = 32'h2222_2222;
    tick();
    idleWrites();
    rsD1 = 5'd5; rtD2 = 5'd6;
    #1;
    check("dual_r5", readDataA1, 32'h1111_1111);
    check("dual_r6", readDataB2, 32'h2222_2222);
    check("dual_writeCount", 32'(writeCount), 32'd2);
    check("dual_waw", 32'(wawCollision), 32'd0);

    // ---- collision on r7: slot 2 wins, counted once
    regWriteW1 = 1'b1; writeRegisterW1 = 5'd7; writeDataW1 = 32'hAAAA_AAAA;
    regWriteW2 = 1'b1; writeRegisterW2 = 5'd7; writeDataW2 = 32'h5555_5555;
    rsD1 = 5'd7;
    #1;
    check("coll_bypass_r7", readDataA1, 32'h5555_5555);
    tick();
    idleWrites();
    #1;
    check("coll_waw_set", 32'(wawCollision), 32'd1);
    check("coll_writeCount", 32'(writeCount), 32'd3);
    check("coll_stored_r7", readDataA1, 32'h5555_5555);
    tick();
    check("coll_waw_clear", 32'(wawCollision), 32'd0);

    // ---- write-first bypass on r9 to two ports
    rtD1 = 5'd9; rsD2 = 5'd9;
    #1;
    check("bypass_pre_r9", readDataB1, 32'd0);
    regWriteW1 = 1'b1; writeRegisterW1 = 5'd9; writeDataW1 = 32'hDEAD_BEEF;
    #1;
    check("bypass_B1_r9", readDataB1, 32'hDEAD_BEEF);
    check("bypass_A2_r9", readDataA2, 32'hDEAD_BEEF);
    tick();
    idleWrites();
    #1;
    check("bypass_stored_r9", readDataA2, 32'hDEAD_BEEF);
    check("bypass_writeCount", 32'(writeCount), 32'd4);

    // ---- register 0: both slots write r0
    regWriteW1 = 1'b1; writeRegisterW1 = 5'd0; writeDataW1 = 32'hFFFF_FFFF;
    regWriteW2 = 1'b1; writeRegisterW2 = 5'd0; writeDataW2 = 32'hFFFF_FFFF;
    rsD1 = 5'd0; rtD1 = 5'd0; rsD2 = 5'd0; rtD2 = 5'd0;
    #1;
    check("r0_A1", readDataA1, 32'd0);
    check("r0_B1", readDataB1, 32'd0);
    check("r0_A2", readDataA2, 32'd0);
    check("r0_B2", readDataB2, 32'd0);
    tick();
    idleWrites();
    #1;
    check("r0_writeCount", 32'(writeCount), 32'd4);
    check("r0_waw", 32'(wawCollision), 32'd0);
    check("r0_stored", readDataA1, 32'd0);

    // ---- same index on both slots but slot 1 disabled: no collision, one write
    regWriteW1 = 1'b0; writeRegisterW1 = 5'd12; writeDataW1 = 32'h0BAD_0BAD;
    regWriteW2 = 1'b1; writeRegisterW2 = 5'd12; writeDataW2 = 32'h0000_CAFE;
    tick();
    idleWrites();
    rsD1 = 5'd12;
    #1;
    check("single_w2_r12", readDataA1, 32'h0000_CAFE);
    check("single_w2_waw", 32'(wawCollision), 32'd0);
    check("single_w2_writeCount", 32'(writeCount), 32'd5);

    // ---- disabled write: no bypass, no store
    regWriteW1 = 1'b0; writeRegisterW1 = 5'd13; writeDataW1 = 32'h1313_1313;
    rsD1 = 5'd13;
    #1;
    check("disabled_nobypass", readDataA1, 32'd0);
    tick();
    idleWrites();
    #1;
    check("disabled_nostore", readDataA1, 32'd0);
    check("disabled_writeCount", 32'(writeCount), 32'd5);

    // ---- reset asserted mid-cycle discards the in-flight write and clears state
    regWriteW1 = 1'b1; writeRegisterW1 = 5'd14; writeDataW1 = 32'h1414_1414;
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    idleWrites();
    tick();
    rsD1 = 5'd14; rtD1 = 5'd5;
    #1;
    check("midrst_r14", readDataA1, 32'd0);
    check("midrst_r5", readDataB1, 32'd0);
    check("midrst_writeCount", 32'(writeCount), 32'd0);

    // ---- counter wrap: 65535 single writes then one dual write
    regWriteW1 = 1'b1; writeRegisterW1 = 5'd1; writeDataW1 = 32'h0000_0001;
    repeat (65535) @(posedge clk);
    #1;
    idleWrites();
    #1;
    check("wrap_ffff", 32'(writeCount), 32'h0000_FFFF);
    regWriteW1 = 1'b1; writeRegisterW1 = 5'd1; writeDataW1 = 32'h0101_0101;
    regWriteW2 = 1'b1; writeRegisterW2 = 5'd2; writeDataW2 = 32'h0202_0202;
    tick();
    idleWrites();
    #1;
    check("wrap_0001", 32'(writeCount), 32'h0000_0001);
    check("wrap_waw", 32'(wawCollision), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/dual_issue_regfile.md
DUAL_ISSUE_REGFILE -- requirements
Module: dual_issue_regfile

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports regWriteW1 and regWriteW2, input, 1 each, write enables for writeback slot 1 and writeback slot 2.
REQ-004 SHALL have ports writeRegisterW1 and writeRegisterW2, input, 5 each, destination register indices.
REQ-005 SHALL have ports writeDataW1 and writeDataW2, input, 32 each, writeback data.
REQ-006 SHALL have ports rsD1, rtD1, rsD2 and rtD2, input, 5 each, decode-stage source indices for issue slots 1 and 2.
REQ-007 SHALL have ports readDataA1, readDataB1, readDataA2 and readDataB2, output, 32 each, source operands for rsD1, rtD1, rsD2 and rtD2.
REQ-008 SHALL have port wawCollision, output, 1, registered flag for a same-cycle dual write to the same register.
REQ-009 SHALL have port writeCount, output, 16, registered count of committed register writes.

Function
REQ-010 SHALL hold 32 registers of 32 bits each; register 0 always reads 0 and is never written.
REQ-011 SHALL write writeDataW1 to writeRegisterW1 on the rising edge when regWriteW1=1 and writeRegisterW1!=0.
REQ-012 SHALL write writeDataW2 to writeRegisterW2 on the rising edge when regWriteW2=1 and writeRegisterW2!=0.
REQ-013 SHALL apply only the slot-2 write when both slots write the same nonzero register in one cycle, because slot 2 is later in program order; the slot-1 data is discarded.
REQ-014 SHALL produce each read combinationally, with zero-cycle latency, from its index.
REQ-015 SHALL bypass write data to a read port when that port's index matches a same-cycle active nonzero write (write-first), so a read never returns stale data.
REQ-016 SHALL use this bypass priority: slot-2 write match, then slot-1 write match, then stored value.
REQ-017 SHALL return 0 for a read of index 0 regardless of any write addressed to index 0.
REQ-018 SHALL set wawCollision to 1 on the edge following a cycle with regWriteW1=regWriteW2=1 and writeRegisterW1=writeRegisterW2!=0, and to 0 after any other cycle.
REQ-019 SHALL add to writeCount, each edge, the number of slots that performed an effective write: 0, 1 or 2.
REQ-020 SHALL count a collided write pair as 1.
REQ-021 SHALL let writeCount wrap modulo 2^16, so 16'hFFFF plus 1 gives 16'h0000.
REQ-022 SHALL give the four read ports no interaction; any combination of equal indices is legal.

Reset
REQ-023 SHALL, while rst=0, asynchronously clear all 32 registers, wawCollision and writeCount to 0, independent of clk.
REQ-024 SHALL drive all read outputs to 0 during reset, except for bypassed write data: the bypass stays combinational, and the write itself is suppressed.
REQ-025 SHALL perform no write on the first edge after reset deassertion unless the enables are asserted in that cycle.
REQ-026 SHALL discard an in-flight write when reset asserts mid-cycle; the register reads 0 afterwards.

Verification
REQ-027 SHALL be tested with this reset check: drive rst=0, then rst=1, then read all indices 1..31 on the four ports -> all read 0, wawCollision=0, writeCount=0.
REQ-028 SHALL be tested with a dual write: W1 writes r5=32'h1111_1111 and W2 writes r6=32'h2222_2222 in one cycle, then rsD1=5 and rtD2=6 are read -> 32'h1111_1111 and 32'h2222_2222, writeCount=2.
REQ-029 SHALL be tested with a collision: W1 writes r7=32'hAAAA_AAAA and W2 writes r7=32'h5555_5555 in the same cycle -> the same-cycle read of r7 returns 32'h5555_5555, the stored value is 32'h5555_5555, wawCollision=1 for one cycle, and writeCount increments by 1.
REQ-030 SHALL be tested with a write-first bypass: W1 writes r9=32'hDEAD_BEEF while rtD1=9 and rsD2=9 in the same cycle -> both ports return 32'hDEAD_BEEF before the edge.
REQ-031 SHALL be tested with register 0: W1 and W2 both write r0=32'hFFFF_FFFF -> every port reading index 0 returns 0, writeCount is unchanged, and wawCollision=0.
REQ-032 SHALL be tested with counter wrap: 65535 single writes followed by one dual write -> writeCount=16'h0001.
